fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/core_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 41 ++++
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core types and widths for the fetch front end.
// Provides the default PC width, instruction width and reset PC.
package core_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction memory, redirect and core handshake.
// master = fetch unit side, slave = memory/core side.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = core_pkg::ADDR_W
);

  logic                        imem_req;
  logic [ADDR_W-1:0]           imem_addr;
  logic [core_pkg::INST_W-1:0] imem_rdata;
  logic                        redirect_valid;
  logic [ADDR_W-1:0]           redirect_pc;
  logic                        inst_valid;
  logic                        inst_ready;
  logic [core_pkg::INST_W-1:0] inst;
  logic [ADDR_W-1:0]           inst_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch entries.
// Flush empties it in one cycle; reset also clears the storage.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = core_pkg::fetch_entry_t,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  entry_t           din,
  input  logic             pop,
  output entry_t           dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  import core_pkg::*;

  localparam int unsigned PTR_W =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_q;
  logic [PTR_W-1:0] wr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ?
      '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_q] <= din;
        wr_q      <= nxt(wr_q);
      end
      if (do_pop) begin
        rd_q <= nxt(rd_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, request throttle and buffer.
// FETCH_BYPASS_EN: forward returning data when the buffer is empty.
module fetch_unit #(
  parameter int unsigned ADDR_W = core_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC =
    ADDR_W'(core_pkg::RESET_PC),
  parameter int unsigned DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  import core_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 2;
  localparam logic [ADDR_W-1:0] PC0 =
    RESET_PC & ~ADDR_W'(3);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] rsp_pc_q;
  logic              inflight_q;
  logic              redirect;
  logic              rsp_live;
  logic              req;
  logic              pop;
  logic              push;
  logic              fifo_pop;
  logic [OCC_W-1:0]  occ;
  entry_t            wdata;
  entry_t            head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  assign redirect = bus.redirect_valid;
  assign rsp_live = inflight_q && !redirect && !rst;
  assign wdata    = '{pc: rsp_pc_q, inst: bus.imem_rdata};

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp = empty && rsp_live;
  assign bus.inst_valid =
    !rst && !redirect && (!empty || rsp_live);
  assign bus.inst    = byp ? bus.imem_rdata : head.inst;
  assign bus.inst_pc = byp ? rsp_pc_q : head.pc;
  assign push =
    rsp_live && !full && !(byp && bus.inst_ready);
  assign fifo_pop =
    !empty && !redirect && !rst && bus.inst_ready;
`else
  assign bus.inst_valid = !rst && !redirect && !empty;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign push           = rsp_live && !full;
  assign fifo_pop       = bus.inst_valid && bus.inst_ready;
`endif

  assign pop = bus.inst_valid && bus.inst_ready;
  assign occ = OCC_W'(count)
             + OCC_W'(rsp_live)
             - OCC_W'(pop);
  assign req = !rst && !redirect
            && (occ < OCC_W'(DEPTH));

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc_q;

  // Fetch PC and in-flight request tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= PC0;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= req;
      if (req) begin
        rsp_pc_q <= pc_q;
      end
      if (redirect) begin
        pc_q <= bus.redirect_pc & ~ADDR_W'(3);
      end else if (req) begin
        pc_q <= pc_q + ADDR_W'(4);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (push),
    .din   (wdata),
    .pop   (fifo_pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// Scoreboard of issued PCs plus redirect vector table.
module tb_fetch_unit;

  localparam int DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        rv;
  logic [31:0] rpc;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] q[$];
  logic [31:0] mpc;
  logic        hold_q = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32)) bus0 ();
  fetch_unit_if #(.ADDR_W(32)) bus1 ();

  fetch_unit #(.DEPTH(DEPTH)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fetch_unit #(.RESET_PC(RPC1), .DEPTH(DEPTH)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign bus0.inst_ready     = ready;
  assign bus0.redirect_valid = rv;
  assign bus0.redirect_pc    = rpc;
  assign bus1.inst_ready     = 1'b1;
  assign bus1.redirect_valid = 1'b0;
  assign bus1.redirect_pc    = 32'h0;

  always @(posedge clk) begin
    bus0.imem_rdata <= bus0.imem_req ?
      memf(bus0.imem_addr) : 32'hDEAD_BEEF;
    bus1.imem_rdata <= bus1.imem_req ?
      memf(bus1.imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input bit ok, input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // Scoreboard: issued PCs are expected back in order.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      mpc    = 32'h0;
      hold_q = 1'b0;
    end else if (rv) begin
      chk(!bus0.imem_req, "redir_noreq", 32'(bus0.imem_req), 0);
      chk(!bus0.inst_valid, "redir_novalid",
          32'(bus0.inst_valid), 0);
      q.delete();
      mpc    = rpc & ~32'h3;
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk(bus0.inst_valid, "hold_valid",
            32'(bus0.inst_valid), 1);
        chk(bus0.inst_pc == hold_pc, "hold_pc",
            bus0.inst_pc, hold_pc);
        chk(bus0.inst == hold_inst, "hold_inst",
            bus0.inst, hold_inst);
      end
      if (bus0.inst_valid && ready) begin
        if (q.size() == 0) begin
          chk(1'b0, "sb_empty", bus0.inst_pc, 0);
        end else begin
          logic [31:0] e;
          e = q.pop_front();
          chk(bus0.inst_pc == e, "sb_pc", bus0.inst_pc, e);
          chk(bus0.inst == memf(e), "sb_inst",
              bus0.inst, memf(e));
        end
      end
      if (bus0.imem_req) begin
        chk(bus0.imem_addr == mpc, "req_addr",
            bus0.imem_addr, mpc);
        q.push_back(mpc);
        mpc = mpc + 32'd4;
      end
      chk(q.size() <= DEPTH, "outstanding",
          32'(q.size()), DEPTH);
      hold_q    = bus0.inst_valid && !ready;
      hold_pc   = bus0.inst_pc;
      hold_inst = bus0.inst;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_first(input logic [31:0] exp,
                            input string nm);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus0.inst_valid && ready) begin
        chk(bus0.inst_pc == exp, nm, bus0.inst_pc, exp);
        found = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!found) chk(1'b0, {nm, "_timeout"}, 0, exp);
  endtask

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] exp;
    int          stall;
    logic        rdy;
  } vec_t;

  vec_t vt[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h0000_0103, 32'h0000_0100, 5, 1'b0};
    vt[1] = '{32'h0000_0200, 32'h0000_0200, 0, 1'b1};
    vt[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 3, 1'b1};
    vt[3] = '{32'h0000_0040, 32'h0000_0040, 1, 1'b0};

    rst = 1'b1; ready = 1'b1; rv = 1'b0; rpc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(!bus0.inst_valid, "rst_valid", 32'(bus0.inst_valid), 0);
    chk(!bus0.imem_req, "rst_req", 32'(bus0.imem_req), 0);
    chk(bus0.inst == 0, "rst_inst", bus0.inst, 0);
    chk(bus0.inst_pc == 0, "rst_pc", bus0.inst_pc, 0);
    chk(bus1.inst_pc == 0, "rst_pc1", bus1.inst_pc, 0);
    step();
    rst = 1'b0;

    for (int c = 0; c < 8; c++) begin
      logic [31:0] e1;
      @(negedge clk);
      chk(bus0.imem_req && bus0.imem_addr == 32'(4 * c),
          "start_addr", bus0.imem_addr, 32'(4 * c));
      chk(bus1.imem_addr == RPC1 + 32'(4 * c),
          "start_addr1", bus1.imem_addr, RPC1 + 32'(4 * c));
      chk(bus0.inst_valid == (c >= LAT), "start_valid",
          32'(bus0.inst_valid), 32'(c >= LAT));
      if (c >= LAT) begin
        e1 = RPC1 + 32'(4 * (c - LAT));
        chk(bus0.inst_pc == 32'(4 * (c - LAT)), "start_pc",
            bus0.inst_pc, 32'(4 * (c - LAT)));
        chk(bus1.inst_valid && bus1.inst_pc == e1, "wrap_pc1",
            bus1.inst_pc, e1);
        chk(bus1.inst == memf(e1), "wrap_inst1",
            bus1.inst, memf(e1));
      end
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 4; i++) begin
      ready = 1'b0;
      repeat (vt[i].stall) step();
      ready = vt[i].rdy;
      rv    = 1'b1;
      rpc   = vt[i].tgt;
      step();
      rv    = 1'b0;
      ready = 1'b0;
      @(negedge clk);
      chk(bus0.imem_req && bus0.imem_addr == vt[i].exp,
          "vec_addr", bus0.imem_addr, vt[i].exp);
      @(posedge clk);
      #1;
      ready = 1'b1;
      wait_first(vt[i].exp, "vec_first");
      repeat (4) step();
    end

    ready = 1'b1;
    repeat (3) step();
    rv  = 1'b1;
    rpc = 32'h0000_0300;
    @(negedge clk);
    chk(!bus0.inst_valid, "prio_valid", 32'(bus0.inst_valid), 0);
    @(posedge clk);
    #1;
    rpc = 32'h0000_0200;
    step();
    rv = 1'b0;
    @(negedge clk);
    chk(bus0.imem_req && bus0.imem_addr == 32'h200,
        "b2b_addr", bus0.imem_addr, 32'h200);
    @(posedge clk);
    #1;
    wait_first(32'h0000_0200, "b2b_first");
    repeat (4) step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk(!bus0.inst_valid, "mid_rst_valid",
        32'(bus0.inst_valid), 0);
    chk(bus0.imem_req && bus0.imem_addr == 32'h0,
        "mid_rst_addr", bus0.imem_addr, 0);
    chk(bus1.imem_addr == RPC1, "mid_rst_addr1",
        bus1.imem_addr, RPC1);
    @(posedge clk);
    #1;
    wait_first(32'h0, "mid_rst_first");
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
